math_display_scan: RTL
======================

Name: math_display_scan

Overview:
- Downstream consumer of the math block: takes the four 4-bit nibbles A, B, AplusB, AminusB and time-multiplexes them onto a 4-digit common-anode seven-segment display as hex digits.
- Contains a refresh prescaler, a 2-bit digit scanner, a tear-free input snapshot register bank and a registered hex-to-segment decoder.
- Sits between the math block outputs and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit); legal range >= 4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- A  input  4  operand A (shown on digit 3, leftmost)
- B  input  4  operand B (digit 2)
- AplusB  input  4  sum (digit 1)
- AminusB  input  4  difference (digit 0, rightmost)
- an  output  4  digit enables, active-low, an[0] = rightmost
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; always 1 (off)

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst), sampled on rising clk.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, prescaler=0, digit index=0, all snapshot nibbles=0, load_pending=1.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. tick = (count == REFRESH_DIV-1). Width is $clog2(REFRESH_DIV).
- Digit index: 2-bit, increments on tick, wraps 3->0.
- Snapshot: all four inputs are captured together into snap[3:0] under either condition:
  - tick while index==3 (start of a new scan).
  - The first cycle with rst=0 after reset while load_pending=1; load_pending then clears.
- Inputs change on the display only at scan boundaries; no digit tearing. Input changes between snapshots are ignored.
- Output stage, registered every cycle:
  - an <= ~(4'b0001 << index).
  - seg <= decode(snap[index]).
  - Latency: 1 clk from an index or snapshot change to the pins.
- After rst falls:
  - first edge -> an=4'b1110, seg=decode(0)=7'h40.
  - second edge -> seg shows the loaded AminusB.
- Decode table, active-low hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Exactly one an bit is low at any time outside reset.
- Full scan period is 4*REFRESH_DIV cycles.
- Reset mid-scan: the next edge with rst=1 forces all reset values, blanking the display. The scan restarts at digit 0 with a fresh snapshot.
- Simultaneous snapshot and tick at index 3: the new snapshot is visible starting with digit 0 of the new scan.

Optional Feature:
- Macro SEVSEG_DIM_EN.
- Defined:
  - Adds port dim, input, 1 bit.
  - When dim=1, an is forced to 4'b1111 whenever prescaler count >= REFRESH_DIV/4 (integer division), giving 25% duty.
  - seg and scan timing are unchanged.
  - dim is sampled each cycle; the effect reaches the pins 1 clk later (registered).
- Undefined: no dim port; full duty always.

Test Plan (REFRESH_DIV=4):
- Reset hold: rst=1 for 3 cycles with inputs A=5,B=3 -> an=1111, seg=7F, dp=1 throughout.
- First frame: rst falls with A=5,B=3,AplusB=8,AminusB=2. Required pins:
  - edge 1: an=1110, seg=40.
  - edge 2: seg=24.
  - digit 0 slot: seg=24.
  - next slots show 8 -> 00, 3 -> 30, 5 -> 12, with an=1101, 1011, 0111, each for 4 cycles.
- Snapshot isolation: change A from 5 to F mid-scan while digit 1 is active. Required response:
  - digit 3 still shows 12 in the current scan.
  - digit 3 shows 0E in the next scan.
- Full decode sweep: drive AminusB through 0..F, one value per scan -> digit 0 seg matches the table for all 16 values.
- Reset mid-operation: assert rst for 1 cycle while index=2. Required response:
  - next edge -> an=1111, seg=7F.
  - after release, the scan restarts at an=1110 with a fresh snapshot.
- SEVSEG_DIM_EN with dim=1: in each 4-cycle digit slot, an is active for exactly 1 cycle (prescaler count 0, delayed 1 clk) and 1111 for the other 3.

Source files
------------

// File: rtl/math_display_scan.sv
// Four-digit common-anode hex display scanner for the math block outputs (A, B, A+B, A-B).
// Optional macro SEVSEG_DIM_EN adds a dim input that cuts the anode duty to 25%.
module math_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] AplusB,
  input  logic [3:0] AminusB,
`ifdef SEVSEG_DIM_EN
  input  logic       dim,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIV - 1);
`ifdef SEVSEG_DIM_EN
  localparam logic [CW-1:0] DIM_THRESHOLD = CW'(REFRESH_DIV / 4);
`endif

  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic [3:0]    snap [4];
  logic          load_pending;
  logic          tick;
  logic          snap_load;
  logic [3:0]    an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Snapshot only at scan boundaries (or right after reset) so a scan never mixes old and new inputs.
  always_comb begin
    tick      = (count == LAST_COUNT);
    snap_load = load_pending || (tick && (idx == 2'd3));
    an_next   = ~(4'b0001 << idx);
`ifdef SEVSEG_DIM_EN
    if (dim && (count >= DIM_THRESHOLD)) an_next = 4'b1111;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      idx          <= 2'd0;
      for (int i = 0; i < 4; i++) snap[i] <= 4'h0;
      load_pending <= 1'b1;
      an           <= 4'b1111;
      seg          <= 7'h7F;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (snap_load) begin
        snap[3] <= A;
        snap[2] <= B;
        snap[1] <= AplusB;
        snap[0] <= AminusB;
      end
      load_pending <= 1'b0;
      an           <= an_next;
      seg          <= hex_to_seg(snap[idx]);
    end
  end

  assign dp = 1'b1;

endmodule
